// File: rtl/fifo_sum_sink.sv
// fifo_sum_sink: read side of a FIFO handshake. Pulls length-prefixed
// records (header word carries N in bits [LEN_W-1:0], then N payload words)
// and pushes one 32-bit wrapping payload sum per record downstream.
// Optional build macro FIFO_SUM_SINK_STATS_EN adds the rec_count port, a
// wrapping count of completed records.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a header word
// PAYLOAD | accumulating payload words, remaining > 0
// EMIT    | sum is on out_enq_v, waiting for downstream to accept it
module fifo_sum_sink #(
  parameter int LEN_W = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_first__RDY,
  input  logic [31:0] in_first,
  input  logic        in_deq__RDY,
  output logic        in_deq__ENA,
  input  logic        out_enq__RDY,
  output logic        out_enq__ENA,
  output logic [31:0] out_enq_v,
  output logic        busy
`ifdef FIFO_SUM_SINK_STATS_EN
  ,
  output logic [15:0] rec_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       sum;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  hdr_len;
  logic              take;

  assign hdr_len = in_first[LEN_W-1:0];

  // Gating with nRST keeps the upstream untouched while reset is held.
  assign take = nRST & in_first__RDY & in_deq__RDY &
                ((state == IDLE) | (state == PAYLOAD));

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_next = (hdr_len == '0) ? EMIT : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (take && (remaining == LEN_W'(1))) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_enq__RDY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; out_enq_v is the sum register itself.
  always_comb begin
    in_deq__ENA  = take;
    out_enq__ENA = (state == EMIT) && out_enq__RDY;
    out_enq_v    = sum;
    busy         = (state != IDLE);
  end

  // Length counter and accumulator; a header take restarts both.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sum       <= '0;
      remaining <= '0;
    end else if (take) begin
      if (state == IDLE) begin
        remaining <= hdr_len;
        sum       <= '0;
      end else begin
        remaining <= remaining - LEN_W'(1);
        sum       <= sum + in_first;
      end
    end
  end

`ifdef FIFO_SUM_SINK_STATS_EN
  // Completed-record counter, wraps at 16 bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rec_count <= '0;
    end else if (out_enq__ENA) begin
      rec_count <= rec_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_sum_sink.md
# fifo_sum_sink

Consumer that pulls 32-bit words from the dequeue end of an upstream single-element FIFO through its `first`/`deq` method handshake. It parses them as length-prefixed records and forwards one 32-bit payload sum per record through an `enq`-style method into a downstream FIFO. It sits between the FIFO dequeue port and any `enq`-capable sink, making it the read side of the FIFO protocol.

## Interface
Parameters:
- `LEN_W`, default 8: width of the record-length field taken from header bits `[LEN_W-1:0]`.

Ports:
- `CLK`  input  1: single clock; all state updates on its rising edge.
- `nRST`  input  1: asynchronous, active-low reset.
- `in_first__RDY`  input  1: upstream has a valid word on `in_first`.
- `in_first`  input  32: upstream head-of-queue word.
- `in_deq__RDY`  input  1: upstream can accept a `deq` this cycle.
- `in_deq__ENA`  output  1: dequeue the upstream head word at this clock edge.
- `out_enq__RDY`  input  1: downstream can accept an `enq` this cycle.
- `out_enq__ENA`  output  1: enqueue `out_enq_v` downstream at this clock edge.
- `out_enq_v`  output  32: record sum being enqueued.
- `busy`  output  1: high while a record is in progress (state not IDLE).
- `rec_count`  output  16: completed-record counter. Present only with `FIFO_SUM_SINK_STATS_EN`.

## Operation
- Record format: one header word with length N = `in_first[LEN_W-1:0]` (upper bits ignored), followed by N payload words.
- Upstream take condition: `take = in_first__RDY & in_deq__RDY & (state is IDLE or PAYLOAD)`.
- `in_deq__ENA = take`, combinational. It is never asserted in EMIT.
- IDLE:
  - On take, latch `remaining = N` and clear `sum = 0`.
  - N = 0: go to EMIT, which produces a zero sum.
  - N ≠ 0: go to PAYLOAD.
- PAYLOAD:
  - On take, `sum <= sum + in_first`, modulo 2^32 with carry discarded.
  - On the same take, `remaining <= remaining - 1`.
  - When take occurs with `remaining == 1`, go to EMIT.
  - No take: hold all state; there is no timeout.
- EMIT:
  - `out_enq_v = sum`, registered.
  - `out_enq__ENA = out_enq__RDY`, combinational, only in this state.
  - On ENA, go to IDLE. The next header may be taken on the following cycle, not the same cycle.
  - While `out_enq__RDY` is low, hold EMIT with `sum` stable and upstream stalled.
- `busy` = (state != IDLE), registered state decode.

## Timing
- Reset (`nRST` low, asynchronous):
  - State = IDLE, `sum` = 0, `remaining` = 0, `rec_count` = 0.
  - `in_deq__ENA` = 0, `out_enq__ENA` = 0, `out_enq_v` = 0, `busy` = 0.
- Reset asserted mid-record: the partial record is discarded and words already dequeued are lost. After release, the next word taken is treated as a header.
- Throughput: with both sides always ready, a record of N payload words occupies N+2 cycles (1 header, N payload, 1 emit). N = 0 occupies 2 cycles.
- Latency: the sum is visible on `out_enq_v` in the cycle after the last payload take.
- Stall rules:
  - Upstream not ready: no take and no state change.
  - Downstream not ready: EMIT holds indefinitely.
- N = 2^LEN_W − 1 (255) is legal; `remaining` is `LEN_W` bits wide.

## Configuration
- `FIFO_SUM_SINK_STATS_EN` defined:
  - The `rec_count` port and register exist.
  - `rec_count` increments by 1 on every EMIT handshake (`out_enq__ENA`) and wraps from 0xFFFF to 0x0000.
  - It is reset to 0 by `nRST`.
- Not defined: the port and register are absent. All other behaviour is identical.

## Test plan
- Both sides ready; feed header 3, then 1, 2, 3 → `in_deq__ENA` high for 4 consecutive cycles; one `out_enq__ENA` pulse with `out_enq_v` = 6 on cycle 5; `busy` low afterwards.
- Header 0 → `out_enq_v` = 0 emitted on the cycle after the header take; the next header is taken 2 cycles after the first.
- Header 2, payload 0xFFFFFFFF, 0x00000002 → `out_enq_v` = 0x00000001 (wrap). Header 0x12345602 → N = 2 (upper bits ignored).
- `out_enq__RDY` held low for 5 cycles in EMIT → `in_deq__ENA` stays 0 and `out_enq_v` stays stable. The handshake occurs when RDY rises, then the state returns to IDLE.
- Header 4, two payload words, then `nRST` pulsed low mid-cycle → all outputs are 0 immediately. After release, word 1 is treated as a header, and header 1 with payload 7 yields `out_enq_v` = 7.
- With `FIFO_SUM_SINK_STATS_EN` defined, run 3 records → `rec_count` = 3. Preload `rec_count` to 0xFFFF via 65535 records (or force) and emit one more → `rec_count` = 0.
